serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//   Downstream consumer of the enable-gated D flip-flop stage. Takes its registered
//   bit output (q) as bit_in and its enable as bit_valid. Assembles a serial bit stream
//   into framed words and checks each frame's parity and stop bit.
//   Reports each completed frame with a one-cycle pulse and keeps a count of good frames.
// PARAMETERS
//   WIDTH  8  data bits per frame (>=2)
//   CNT_W  8  width of good-frame counter (wraps)
// PORTS
//   clk          in   1        rising-edge clock, single clock domain
//   rst_n        in   1        asynchronous active-low reset
//   clear        in   1        synchronous abort: force IDLE, zero frame_count
//   bit_valid    in   1        bit_in is sampled only on edges where this is 1
//   bit_in       in   1        serial data bit (upstream q)
//   data_out     out  WIDTH    last received data word, LSB first on the wire
//   data_valid   out  1        1-cycle pulse: frame completed, outputs updated
//   parity_err   out  1        last frame failed even parity
//   frame_err    out  1        last frame had bad stop bit
//   busy         out  1        1 while state != IDLE
//   frame_count  out  CNT_W    count of error-free frames, modulo 2^CNT_W
// BEHAVIOUR
//   Frame on wire, counting valid bits only: start(1), WIDTH data bits LSB first,
//     parity bit, stop(0). Parity is even: XOR of data and parity bits must be 0.
//   Reset (rst_n=0, async): state=IDLE, shift reg=0, bit_cnt=0, data_out=0,
//     data_valid=0, parity_err=0, frame_err=0, frame_count=0. busy=0.
//   Edges with bit_valid=0 change nothing except data_valid, which returns to 0.
//     Gaps of any length inside a frame are legal.
//   FSM (advances only on edges with bit_valid=1):
//     IDLE   : bit_in=1 -> DATA, bit_cnt=0. bit_in=0 -> stay, idle line.
//     DATA   : shift bit_in into shift reg at MSB (LSB-first assembly), bit_cnt++.
//              After the WIDTH-th bit -> PARITY.
//     PARITY : store parity_calc = ^shift_reg ^ bit_in -> STOP.
//     STOP   : data_out<=shift_reg, parity_err<=parity_calc, frame_err<=bit_in,
//              data_valid<=1, frame_count++ iff both errors 0 (wraps at 2^CNT_W).
//              -> IDLE.
//   Latency: data_valid is high in the cycle after the edge that samples the stop bit.
//     data_out, parity_err and frame_err are valid from that cycle and hold until the
//     next frame completes.
//   Error frames still pulse data_valid and update data_out. frame_count does not change.
//   Back-to-back frames: the earliest next start bit is sampled on the edge after the
//     STOP edge. There is no dead cycle required beyond that.
//   clear=1 overrides bit_valid on the same edge: state=IDLE, bit_cnt=0, frame_count=0,
//     data_valid=0. data_out and error flags hold.
//   rst_n asserted mid-frame aborts the frame immediately. No data_valid for it.
//   bit_cnt width is $clog2(WIDTH)+1. No arithmetic overflow other than the
//     frame_count wrap.
// TESTING
//   1) WIDTH=8: bits 1, A5 LSB-first, 0, 0 -> data_valid 1 cycle, data_out=8'hA5,
//      parity_err=0, frame_err=0, frame_count=1.
//   2) Same frame with parity bit 1 -> data_valid, data_out=8'hA5, parity_err=1,
//      frame_count unchanged.
//   3) Frame 8'h3C with stop bit 1 -> frame_err=1, parity_err=0, count unchanged.
//      Next good frame clears both flags.
//   4) Frame 8'h81 with random bit_valid gaps of 0-5 cycles -> result identical to a
//      gap-free frame. busy=1 throughout.
//   5) rst_n low after 4 data bits -> all outputs 0 asynchronously. A following good
//      frame of 8'h5A is received correctly.
//   6) CNT_W=2: 4 good back-to-back frames -> frame_count 1,2,3,0.
//      clear mid-frame -> busy=0, count=0.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, even parity, stop(0).
// Pulses data_valid per completed frame and counts error-free frames.
module serial_frame_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int BCW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [BCW-1:0]   r_bit_cnt;
  logic             r_parity_calc;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_parity_err;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_frame_count;
  logic             w_last_data;

  assign w_last_data = (r_bit_cnt == BCW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bit_valid) begin
      case (r_state)
        S_IDLE:   if (bit_in) w_next = S_DATA;
        S_DATA:   if (w_last_data) w_next = S_PARITY;
        S_PARITY: w_next = S_STOP;
        S_STOP:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Gated-off edges leave everything alone except the data_valid pulse, which drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_parity_calc <= 1'b0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_data_valid <= 1'b0;
      if (clear) begin
        r_bit_cnt     <= '0;
        r_frame_count <= '0;
      end else if (bit_valid) begin
        case (r_state)
          S_IDLE: begin
            if (bit_in) r_bit_cnt <= '0;
          end
          S_DATA: begin
            r_shift   <= {bit_in, r_shift[WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + BCW'(1);
          end
          S_PARITY: begin
            r_parity_calc <= (^r_shift) ^ bit_in;
          end
          S_STOP: begin
            r_data_out   <= r_shift;
            r_parity_err <= r_parity_calc;
            r_frame_err  <= bit_in;
            r_data_valid <= 1'b1;
            if (!r_parity_calc && !bit_in) r_frame_count <= r_frame_count + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != S_IDLE);
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: a default instance (CNT_W=8) and a CNT_W=2
// instance share all inputs so the counter wrap can be seen.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;

  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;
  logic [7:0] frame_count;

  logic [7:0] d2_data_out;
  logic       d2_data_valid, d2_parity_err, d2_frame_err, d2_busy;
  logic [1:0] d2_frame_count;

  int checks = 0;
  int failures = 0;
  bit chk_busy = 1'b0;

  always #5 clk = ~clk;

  serial_frame_rx #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .frame_count(frame_count)
  );

  serial_frame_rx #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(d2_data_out), .data_valid(d2_data_valid), .parity_err(d2_parity_err),
    .frame_err(d2_frame_err), .busy(d2_busy), .frame_count(d2_frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Optional idle gap cycles, then one valid bit presented for the next rising edge.
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bit_valid = 1'b0;
      if (chk_busy) check("busy_in_gap", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int maxgap);
    send_bit(1'b1, 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(maxgap, 0));
    send_bit(par, $urandom_range(maxgap, 0));
    send_bit(stp, $urandom_range(maxgap, 0));
  endtask

  // Sample just after the stop-bit edge: the completion pulse is visible here.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe, input logic [7:0] cnt);
    @(posedge clk);
    #1;
    check({tag, "_dv"},   {31'd0, data_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, data_out},   {24'd0, d});
    check({tag, "_perr"}, {31'd0, parity_err}, {31'd0, pe});
    check({tag, "_ferr"}, {31'd0, frame_err},  {31'd0, fe});
    check({tag, "_cnt"},  {24'd0, frame_count}, {24'd0, cnt});
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_data",  {24'd0, data_out},    32'd0);
    check("rst_dv",    {31'd0, data_valid},  32'd0);
    check("rst_perr",  {31'd0, parity_err},  32'd0);
    check("rst_ferr",  {31'd0, frame_err},   32'd0);
    check("rst_busy",  {31'd0, busy},        32'd0);
    check("rst_cnt",   {24'd0, frame_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go_idle(2);

    // 1) Good frame A5
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    expect_frame("t1", 8'hA5, 1'b0, 1'b0, 8'd1);
    go_idle(1);
    @(posedge clk);
    #1;
    check("t1_dv_pulse", {31'd0, data_valid}, 32'd0);
    check("t1_hold",     {24'd0, data_out},   32'h0000_00A5);
    check("t1_idle",     {31'd0, busy},       32'd0);

    // 2) Parity error
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    expect_frame("t2", 8'hA5, 1'b1, 1'b0, 8'd1);
    go_idle(2);

    // 3) Bad stop bit, then a good frame clears both flags
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    expect_frame("t3", 8'h3C, 1'b0, 1'b1, 8'd1);
    go_idle(2);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    expect_frame("t3b", 8'h3C, 1'b0, 1'b0, 8'd2);
    go_idle(2);

    // 4) Frame with random gaps inside; busy must stay up across them
    chk_busy = 1'b0;
    send_bit(1'b1, 0);
    chk_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(logic'(8'h81 >> i), $urandom_range(5, 0));
    send_bit(1'b0, $urandom_range(5, 0));
    send_bit(1'b0, $urandom_range(5, 0));
    chk_busy = 1'b0;
    expect_frame("t4", 8'h81, 1'b0, 1'b0, 8'd3);
    go_idle(2);

    // 5) Async reset after 4 data bits
    send_bit(1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(logic'(8'h77 >> i), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_data", {24'd0, data_out},    32'd0);
    check("t5_cnt",  {24'd0, frame_count}, 32'd0);
    check("t5_busy", {31'd0, busy},        32'd0);
    check("t5_perr", {31'd0, parity_err},  32'd0);
    check("t5_ferr", {31'd0, frame_err},   32'd0);
    check("t5_dv",   {31'd0, data_valid},  32'd0);
    go_idle(1);
    rst_n = 1'b1;
    go_idle(1);
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    expect_frame("t5b", 8'h5A, 1'b0, 1'b0, 8'd1);
    go_idle(1);

    // 6) clear, then back-to-back frames; small counter wraps 1,2,3,0
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t6_clr_cnt",  {24'd0, frame_count},    32'd0);
    check("t6_clr_cnt2", {30'd0, d2_frame_count}, 32'd0);
    check("t6_clr_hold", {24'd0, data_out},       32'h0000_005A);
    send_frame(8'h0F, 1'b0, 1'b0, 0);
    expect_frame("t6a", 8'h0F, 1'b0, 1'b0, 8'd1);
    check("t6a_cnt2", {30'd0, d2_frame_count}, 32'd1);
    send_frame(8'h01, 1'b1, 1'b0, 0);
    expect_frame("t6b", 8'h01, 1'b0, 1'b0, 8'd2);
    check("t6b_cnt2", {30'd0, d2_frame_count}, 32'd2);
    send_frame(8'hFF, 1'b0, 1'b0, 0);
    expect_frame("t6c", 8'hFF, 1'b0, 1'b0, 8'd3);
    check("t6c_cnt2", {30'd0, d2_frame_count}, 32'd3);
    send_frame(8'hC3, 1'b0, 1'b0, 0);
    expect_frame("t6d", 8'hC3, 1'b0, 1'b0, 8'd4);
    check("t6d_cnt2", {30'd0, d2_frame_count}, 32'd0);
    check("t6d_dv2",  {31'd0, d2_data_valid},  32'd1);

    // clear mid-frame, with bit_valid also high on that edge
    send_bit(1'b1, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    @(negedge clk);
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bit_valid = 1'b0;
    check("t6_clr_busy",  {31'd0, busy},           32'd0);
    check("t6_clr_busy2", {31'd0, d2_busy},        32'd0);
    check("t6_clr_cnt_m", {24'd0, frame_count},    32'd0);
    check("t6_clr_dv",    {31'd0, data_valid},     32'd0);
    check("t6_clr_data",  {24'd0, data_out},       32'h0000_00C3);
    go_idle(3);
    check("t6_after_clr", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
